// File: rtl/cbus_arbiter_if.sv
// Cache-bus request/response types and the bundle of per-requester and
// memory-side channels shared between the caches, the arbiter and the bridge.
package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

interface cbus_arbiter_if #(
  parameter int NUM_REQ = 2
);
  cbus_pkg::cbus_req_t  [NUM_REQ-1:0] ireqs;
  cbus_pkg::cbus_resp_t [NUM_REQ-1:0] iresps;
  cbus_pkg::cbus_req_t                oreq;
  cbus_pkg::cbus_resp_t               oresp;

  // slave: the arbiter's view; master: the caches plus memory bridge around it
  modport slave  (input ireqs, input oresp, output iresps, output oreq);
  modport master (output ireqs, output oresp, input iresps, input oreq);
endinterface

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one cache-to-memory bus among NUM_REQ requesters;
// a grant is held until the beat carrying both ready and last.
module cbus_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             resetn,
  cbus_arbiter_if.slave    bus,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   sel_reg, sel_next;
  logic [IDX_W-1:0]   last_reg, last_next;

  logic [NUM_REQ-1:0]   valids;
  logic [2*NUM_REQ-1:0] valids_dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ-1:0]   first_hot;
  logic [IDX_W:0]       start;
  logic [IDX_W:0]       off;
  logic [IDX_W:0]       win_sum;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic [IDX_W:0][NUM_REQ-1:0] bitmask;

  genvar gi, gj;

  // Per-requester valid gather and response steering
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign valids[gi]     = bus.ireqs[gi].valid;
      assign bus.iresps[gi] = (state_reg == BUSY && sel_reg == IDX_W'(gi)) ? bus.oresp : '0;
    end
  endgenerate

  // Constant masks turning the one-hot winner offset into a binary offset
  generate
    for (gj = 0; gj <= IDX_W; gj++) begin : g_enc
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_bit
        assign bitmask[gj][gi] = 1'(gi >> gj);
      end
      assign off[gj] = |(first_hot & bitmask[gj]);
    end
  endgenerate

  // Rotate the valid vector so position 0 is the requester after last_reg;
  // doubling the vector keeps the wrap correct for any NUM_REQ.
  always_comb begin
    start = {1'b0, last_reg} + 1'b1;
    if (start == (IDX_W+1)'(NUM_REQ)) begin
      start = '0;
    end
    valids_dbl = {valids, valids};
    rot        = valids_dbl[start +: NUM_REQ];
    first_hot  = rot & (~rot + 1'b1);
    win_found  = |rot;
    win_sum    = start + off;
    if (win_sum >= (IDX_W+1)'(NUM_REQ)) begin
      win_sum = win_sum - (IDX_W+1)'(NUM_REQ);
    end
    win_idx = win_sum[IDX_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      last_reg  <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    bus.oreq   = '0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          sel_next   = win_idx;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // Forwarded as-is, even if the owner drops valid mid-burst
        bus.oreq = bus.ireqs[sel_reg];
        if (bus.oresp.ready && bus.oresp.last) begin
          state_next = IDLE;
          last_next  = sel_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg == BUSY);
  assign grant_idx = sel_reg;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter with three requesters: single bursts,
// round-robin rotation, back-pressure, asynchronous reset and completion overlap.
module tb_cbus_arbiter;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       busy;
  logic [1:0] grant_idx;
  int         n_checks = 0;
  int         n_fail = 0;

  cbus_arbiter_if #(.NUM_REQ(N)) bus ();

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    resetn   = 1'b0;
    bus.ireqs = '0;
    bus.oresp = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic make_req(input logic [1:0] r, input logic wr, input logic [31:0] addr,
                          input logic [7:0] len);
    cbus_pkg::cbus_req_t q;
    q          = '0;
    q.valid    = 1'b1;
    q.is_write = wr;
    q.size     = 3'd3;
    q.addr     = addr;
    q.strobe   = wr ? 8'hff : 8'h00;
    q.data     = {32'hd0d0_0000, addr};
    q.len      = len;
    bus.ireqs[r] = q;
  endtask

  // Called just after the edge that granted r; returns just after the completion edge.
  task automatic serve(input logic [1:0] r, input int beats, input int gap, input int late);
    int         beat = 0;
    int         c = 0;
    logic       rdy, lst;
    logic [63:0] d;
    while (beat < beats && c < 1000) begin
      rdy = ((c % (gap + 1)) == 0);
      lst = rdy && (beat == beats - 1);
      d   = {30'h0, r, 32'(beat)};
      bus.oresp.ready = rdy;
      bus.oresp.last  = lst;
      bus.oresp.data  = d;
      if (lst && late >= 0) make_req(2'(late), 1'b0, 32'h0000_3000, 8'd0);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL serve_busy: req %0d beat %0d got %b required 1", r, beat, busy);
      end
      n_checks++;
      if (grant_idx !== r) begin
        n_fail++; $display("FAIL serve_grant: got %0d required %0d", grant_idx, r);
      end
      n_checks++;
      if (bus.oreq !== bus.ireqs[r]) begin
        n_fail++; $display("FAIL serve_oreq: req %0d got %h required %h", r, bus.oreq, bus.ireqs[r]);
      end
      n_checks++;
      if (bus.iresps[r] !== {rdy, lst, d}) begin
        n_fail++; $display("FAIL serve_resp: req %0d cycle %0d got %h required %h", r, c, bus.iresps[r], {rdy, lst, d});
      end
      for (int i = 0; i < N; i++) begin
        if (2'(i) != r) begin
          n_checks++;
          if (bus.iresps[2'(i)] !== '0) begin
            n_fail++; $display("FAIL serve_other_resp: req %0d got %h required 0", i, bus.iresps[2'(i)]);
          end
        end
      end
      @(posedge clk);
      #1;
      if (rdy) beat++;
      c++;
    end
    bus.oresp    = '0;
    bus.ireqs[r] = '0;
    $display("burst: requester %0d, %0d beats over %0d cycles", r, beats, c);
  endtask

  task automatic check_idle(input string name, input logic [1:0] exp_grant);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_busy: got %b required 0", name, busy);
    end
    n_checks++;
    if (bus.oreq.valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_oreq_valid: got %b required 0", name, bus.oreq.valid);
    end
    n_checks++;
    if (grant_idx !== exp_grant) begin
      n_fail++; $display("FAIL %s_grant_idx: got %0d required %0d", name, grant_idx, exp_grant);
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    bus.ireqs = '0;
    make_req(2'd1, 1'b0, 32'h0000_0100, 8'd0);
    bus.oresp = {1'b1, 1'b1, 64'hff};
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b required 0", busy);
    end
    n_checks++;
    if (grant_idx !== 2'd0) begin
      n_fail++; $display("FAIL reset_grant_idx: got %0d required 0", grant_idx);
    end
    n_checks++;
    if (bus.oreq !== '0) begin
      n_fail++; $display("FAIL reset_oreq: got %h required 0", bus.oreq);
    end
    n_checks++;
    if (bus.iresps !== '0) begin
      n_fail++; $display("FAIL reset_iresps: got %h required 0", bus.iresps);
    end
    @(posedge clk);
    #1;
    bus.ireqs = '0;
    bus.oresp = '0;
    resetn    = 1'b1;
    check_idle("reset_release", 2'd0);
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_single();
    apply_reset();
    make_req(2'd1, 1'b0, 32'h0000_1000, 8'd15);
    check_idle("single_no_bypass", 2'd0);
    n_checks++;
    if (bus.iresps !== '0) begin
      n_fail++; $display("FAIL single_idle_resps: got %h required 0", bus.iresps);
    end
    @(posedge clk);
    #1;
    serve(2'd1, 16, 0, -1);
    check_idle("single_done", 2'd1);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    make_req(2'd0, 1'b0, 32'h0000_0a00, 8'd3);
    make_req(2'd1, 1'b0, 32'h0000_0b00, 8'd3);
    check_idle("simul_pre", 2'd0);
    @(posedge clk);
    #1;
    serve(2'd0, 4, 0, -1);
    check_idle("simul_gap", 2'd0);
    @(posedge clk);
    #1;
    serve(2'd1, 4, 0, -1);
    check_idle("simul_done", 2'd1);
    // With last=1, requester 2 would be next; it is idle, so 0 must beat 1
    make_req(2'd0, 1'b0, 32'h0000_0c00, 8'd0);
    make_req(2'd1, 1'b0, 32'h0000_0d00, 8'd0);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (grant_idx !== 2'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL simul_last_ptr: got grant %0d busy %b required grant 0 busy 1", grant_idx, busy);
    end
  endtask

  task automatic test_contention();
    int         waited [N];
    logic [1:0] exp_r;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      waited[i] = 0;
      make_req(2'(i), 1'b0, 32'h0000_4000 + 32'(i), 8'd1);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) begin
      exp_r = 2'(k % N);
      serve(exp_r, 2, 0, -1);
      check_idle("contention_gap", exp_r);
      for (int i = 0; i < N; i++) begin
        if (2'(i) == grant_idx) waited[i] = 0;
        else waited[i]++;
        n_checks++;
        if (waited[i] > N - 1) begin
          n_fail++; $display("FAIL contention_starve: req %0d waited %0d bursts, required <= %0d", i, waited[i], N - 1);
        end
      end
      make_req(exp_r, 1'b0, 32'h0000_4000 + 32'(exp_r), 8'd1);
      @(posedge clk);
      #1;
    end
    bus.ireqs = '0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    make_req(2'd2, 1'b1, 32'h0000_2000, 8'd3);
    check_idle("bp_pre", 2'd0);
    @(posedge clk);
    #1;
    serve(2'd2, 4, 2, -1);
    check_idle("bp_done", 2'd2);
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    make_req(2'd0, 1'b0, 32'h0000_5000, 8'd7);
    make_req(2'd1, 1'b0, 32'h0000_6000, 8'd7);
    @(posedge clk);
    #1;
    for (int b = 0; b < 2; b++) begin
      bus.oresp = {1'b1, 1'b0, 64'(b)};
      @(negedge clk);
      n_checks++;
      if (bus.iresps[0].ready !== 1'b1 || grant_idx !== 2'd0) begin
        n_fail++; $display("FAIL midrst_beat: beat %0d got ready %b grant %0d required 1 and 0", b, bus.iresps[0].ready, grant_idx);
      end
      @(posedge clk);
      #1;
    end
    bus.oresp = {1'b1, 1'b0, 64'h2};
    resetn = 1'b0;
    #1;
    n_checks++;
    if (bus.oreq.valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: got valid %b busy %b required 0 0", bus.oreq.valid, busy);
    end
    n_checks++;
    if (bus.iresps !== '0) begin
      n_fail++; $display("FAIL midrst_iresps: got %h required 0", bus.iresps);
    end
    bus.ireqs[0] = '0;
    bus.oresp    = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check_idle("midrst_release", 2'd0);
    @(posedge clk);
    #1;
    serve(2'd1, 2, 0, -1);
    $display("reset mid-burst: requester 1 regranted after release");
  endtask

  task automatic test_completion_overlap();
    apply_reset();
    make_req(2'd1, 1'b0, 32'h0000_7000, 8'd2);
    @(negedge clk);
    @(posedge clk);
    #1;
    serve(2'd1, 3, 0, 0);
    check_idle("overlap_no_regrant", 2'd1);
    @(posedge clk);
    #1;
    serve(2'd0, 1, 0, -1);
    check_idle("overlap_done", 2'd0);
  endtask

  initial begin
    bus.ireqs = '0;
    bus.oresp = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_contention();
    test_backpressure();
    test_reset_mid_burst();
    test_completion_overlap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
